// File: rtl/lif_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lif_pkg
//  Brief    : Shared defaults and helpers for the LIF neuron array:
//             refractory-counter width, saturating add, lowest-set-bit pick.
//  Revision : 1.0 - initial release
// ============================================================================
package lif_pkg;

   localparam int LIF_N_CH_DEF   = 4;
   localparam int LIF_W_DEF      = 8;
   localparam int LEAK_SHIFT_DEF = 1;
   localparam int REFRAC_DEF     = 3;

   // Width of a counter that must hold 0..refrac; never narrower than 1 bit.
   function automatic int refrac_width(input int refrac);
      if (refrac < 1) begin
         return 1;
      end
      return $clog2(refrac + 1);
   endfunction

   // a + b clamped to 2**w-1. Operands are zero-extended w-bit values, so the
   // result always fits in the low w bits.
   function automatic logic [31:0] sat_add(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input int          w);
      logic [32:0] sum;
      logic [32:0] lim;
      sum = {1'b0, a} + {1'b0, b};
      lim = (33'd1 << w) - 33'd1;
      return (sum > lim) ? lim[31:0] : sum[31:0];
   endfunction

   // Index of the lowest set bit; 0 when the mask is empty.
   function automatic int lowest_set(input logic [31:0] mask);
      int idx;
      idx = 0;
      for (int i = 31; i >= 0; i--) begin
         if (mask[i]) begin
            idx = i;
         end
      end
      return idx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/spike_event_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : spike_event_arbiter
//  Brief    : Collects spike pulses into a pending mask and serialises them
//             as channel-ID events over valid/ready, lowest index first.
//             Re-spiking on a channel whose event is still pending merges the
//             two and raises a sticky overflow flag.
//  Revision : 1.0 - initial release
// ============================================================================
module spike_event_arbiter
   import lif_pkg::*;
#(
   parameter int N_CH = LIF_N_CH_DEF
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_CH-1:0]           spike_set_i,
   input  logic                      evt_ready_i,
   output logic                      evt_valid_o,
   output logic [$clog2(N_CH)-1:0]   evt_ch_o,
   output logic                      evt_overflow_o
);

   localparam int CH_W = $clog2(N_CH);

   logic [N_CH-1:0] pending_q, pending_d;
   logic            evt_valid_q, evt_valid_d;
   logic [CH_W-1:0] evt_ch_q, evt_ch_d;
   logic            ovf_q, ovf_d;

   logic            w_hs;
   logic [N_CH-1:0] w_hs_mask;
   logic [N_CH-1:0] w_avail;
   logic [31:0]     w_avail_ext;

   // Next-state: retire the handshaked channel, merge new spikes, reload the
   // output register whenever it is empty or being consumed.
   always_comb begin
      w_hs = evt_valid_q & evt_ready_i;
      for (int k = 0; k < N_CH; k++) begin
         w_hs_mask[k] = w_hs && (evt_ch_q == CH_W'(k));
      end
      w_avail                = pending_q & ~w_hs_mask;
      w_avail_ext            = '0;
      w_avail_ext[N_CH-1:0]  = w_avail;

      // A spike on the channel being retired this edge simply re-arms it.
      pending_d = w_avail | spike_set_i;
      ovf_d     = ovf_q | (|(spike_set_i & w_avail));

      evt_valid_d = evt_valid_q;
      evt_ch_d    = evt_ch_q;
      if (!evt_valid_q || w_hs) begin
         evt_valid_d = |w_avail;
         if (|w_avail) begin
            evt_ch_d = CH_W'(lowest_set(w_avail_ext));
         end
      end
   end

   // State registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q   <= '0;
         evt_valid_q <= 1'b0;
         evt_ch_q    <= '0;
         ovf_q       <= 1'b0;
      end else begin
         pending_q   <= pending_d;
         evt_valid_q <= evt_valid_d;
         evt_ch_q    <= evt_ch_d;
         ovf_q       <= ovf_d;
      end
   end

   assign evt_valid_o    = evt_valid_q;
   assign evt_ch_o       = evt_ch_q;
   assign evt_overflow_o = ovf_q;

endmodule
`default_nettype wire

// File: rtl/lif_neuron_array.sv
`default_nettype none
// ============================================================================
//  Module   : lif_neuron_array
//  Brief    : N_CH parallel leaky integrate-and-fire neurons with programmable
//             thresholds, shift leak, saturating membrane and refractory
//             period; spikes as a pulse vector plus a channel-ID event stream.
//  Revision : 1.0 - initial release
// ============================================================================
module lif_neuron_array
   import lif_pkg::*;
#(
   parameter int N_CH       = LIF_N_CH_DEF,
   parameter int W          = LIF_W_DEF,
   parameter int LEAK_SHIFT = LEAK_SHIFT_DEF,
   parameter int REFRAC     = REFRAC_DEF
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      step,
   input  logic [N_CH*W-1:0]         in_current,
   input  logic                      thr_we,
   input  logic [$clog2(N_CH)-1:0]   thr_ch,
   input  logic [W-1:0]              thr_data,
   output logic [N_CH-1:0]           spike,
   output logic [N_CH*W-1:0]         state_flat,
   output logic                      evt_valid,
   output logic [$clog2(N_CH)-1:0]   evt_ch,
   input  logic                      evt_ready,
   output logic                      evt_overflow
);

   localparam int           CH_W     = $clog2(N_CH);
   localparam int           REFRAC_W = refrac_width(REFRAC);
   localparam logic [W-1:0] THR_RST  = {1'b1, {(W-1){1'b0}}};

   logic [N_CH-1:0] w_spike_set;

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      logic [W-1:0]        v_q, v_d;
      logic [W-1:0]        thr_q, thr_d;
      logic [REFRAC_W-1:0] rf_q, rf_d;
      logic                sp_q, sp_d;
      logic [31:0]         w_base, w_cur, w_n, w_thr;

      // Integrate/fire decision for this channel; threshold write lands
      // after any same-cycle step has compared against the old value.
      always_comb begin
         w_base          = '0;
         w_base[W-1:0]   = v_q - (v_q >> LEAK_SHIFT);
         w_cur           = '0;
         w_cur[W-1:0]    = in_current[k*W +: W];
         w_n             = sat_add(w_base, w_cur, W);
         w_thr           = '0;
         w_thr[W-1:0]    = thr_q;

         thr_d = thr_q;
         if (thr_we && (thr_ch == CH_W'(k))) begin
            thr_d = thr_data;
         end

         v_d  = v_q;
         rf_d = rf_q;
         sp_d = 1'b0;
         if (step) begin
            if (thr_q == '0) begin
               v_d  = '0;
               rf_d = '0;
            end else if (rf_q != '0) begin
               v_d  = '0;
               rf_d = rf_q - REFRAC_W'(1);
            end else if (w_n >= w_thr) begin
               sp_d = 1'b1;
               v_d  = '0;
               rf_d = REFRAC_W'(REFRAC);
            end else begin
               v_d  = w_n[W-1:0];
            end
         end
      end

      // Channel state registers.
      always_ff @(posedge clk) begin
         if (reset) begin
            v_q   <= '0;
            thr_q <= THR_RST;
            rf_q  <= '0;
            sp_q  <= 1'b0;
         end else begin
            v_q   <= v_d;
            thr_q <= thr_d;
            rf_q  <= rf_d;
            sp_q  <= sp_d;
         end
      end

      assign w_spike_set[k]         = sp_d;
      assign spike[k]               = sp_q;
      assign state_flat[k*W +: W]   = v_q;
   end

   spike_event_arbiter #(
      .N_CH (N_CH)
   ) u_arb (
      .clk            (clk),
      .reset          (reset),
      .spike_set_i    (w_spike_set),
      .evt_ready_i    (evt_ready),
      .evt_valid_o    (evt_valid),
      .evt_ch_o       (evt_ch),
      .evt_overflow_o (evt_overflow)
   );

endmodule
`default_nettype wire
